alu_writeback: RTL
==================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DATA_W, default 16, ALU result width.
REQ-002 Parameter ADDR_W, default 4, register-file address width.
REQ-003 Parameter R15_ADDR, default 15, destination of the high-product/remainder word.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  ALU result bundle present.
REQ-007 in_ready  output  1  block accepts bundle this cycle.
REQ-008 alu_sel  input  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 move, 5 swap, 6 and, 7 or.
REQ-009 op1_addr, op2_addr  input  ADDR_W each  destination registers for op1data and op2data.
REQ-010 op1data, op2data, r15  input  DATA_W each  ALU outputs.
REQ-011 rf_we  output  1  register-file write strobe.
REQ-012 rf_waddr  output  ADDR_W  write address.
REQ-013 rf_wdata  output  DATA_W  write data.
REQ-014 busy  output  1  sequence in progress.
REQ-015 retire_cnt  output  16  count of completed bundles.

Function
REQ-016 Bundle accepted when in_valid && in_ready; all inputs latched on that edge.
REQ-017 Write plan by opcode: add/sub/move/and/or -> op1 only; mul/div -> op1 then r15; swap -> op1 then op2.
REQ-018 FSM states IDLE, WR_OP1, WR_SECOND; WR_SECOND writes op2 (swap) or r15 (mul/div).
REQ-019 Transitions: IDLE -accept-> WR_OP1; WR_OP1 -> WR_SECOND if plan has a second write, else IDLE or WR_OP1 (if new accept); WR_SECOND -> IDLE or WR_OP1 (if new accept).
REQ-020 Exactly one register write per cycle; rf_we high only in WR_OP1 and WR_SECOND.
REQ-021 WR_OP1 drives rf_waddr=op1_addr, rf_wdata=op1data; WR_SECOND drives op2_addr/op2data or R15_ADDR/r15.
REQ-022 Latency: first write asserted the cycle after acceptance; single-write ops 1 cycle, two-write ops 2 cycles.
REQ-023 in_ready high in IDLE and in the final write cycle of a sequence (back-to-back, no bubble); combinational from state and latched plan only, never from in_valid.
REQ-024 busy high in WR_OP1 and WR_SECOND.
REQ-025 Address collision (swap with op1_addr==op2_addr, or mul/div with op1_addr==R15_ADDR): both writes still issued in order; second write wins.
REQ-026 retire_cnt increments by 1 on the final write cycle of each bundle; wraps 0xFFFF -> 0x0000.
REQ-027 Data passed unmodified; no sign extension or arithmetic in this block.
REQ-028 rf_waddr/rf_wdata are don't-care when rf_we low, but held at 0 in IDLE.

Reset
REQ-029 rst high on a rising edge forces IDLE, in_ready=1, busy=0, rf_we=0, rf_waddr=0, rf_wdata=0, retire_cnt=0.
REQ-030 rst mid-sequence abandons remaining writes; no write issued in the cycle following reset; the abandoned bundle is not counted.
REQ-031 Bundle presented with in_valid during rst is not accepted.

Structure
REQ-032 Shared package alu_pkg holds opcode constants (ALU_ADD..ALU_OR), DATA_W, ADDR_W, R15_ADDR, and the FSM state enumeration.
REQ-033 One combinational sub-module alu_wb_plan maps alu_sel to a 3-bit write mask {op1, op2, r15}.

Verification
REQ-034 add, op1_addr=3, op1data=25 -> one cycle later rf_we=1, rf_waddr=3, rf_wdata=25; next cycle rf_we=0; retire_cnt=1.
REQ-035 mul 5*-5, op1_addr=2, op1data=0xFFE7, r15=0xFFFF -> writes (2,0xFFE7) then (15,0xFFFF); in_ready low during first write.
REQ-036 swap, op1_addr=op2_addr=4, op1data=2, op2data=100 -> writes (4,2) then (4,100); final value 100.
REQ-037 Back-to-back: add then or with in_valid held -> writes on consecutive cycles, no idle gap; retire_cnt=2.
REQ-038 div 5/2 accepted, rst asserted in WR_OP1 cycle -> no r15 write, all outputs reset values, retire_cnt=0.
REQ-039 retire_cnt preloaded via 65535 single-write bundles -> next retire yields retire_cnt=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings and FSM state type for the ALU writeback slice.
package alu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int R15_ADDR = 15;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_MUL  = 3'd2;
    localparam logic [2:0] ALU_DIV  = 3'd3;
    localparam logic [2:0] ALU_MOVE = 3'd4;
    localparam logic [2:0] ALU_SWAP = 3'd5;
    localparam logic [2:0] ALU_AND  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    // Write masks are ordered {op1, op2, r15}.
    localparam logic [2:0] WM_OP1     = 3'b100;
    localparam logic [2:0] WM_OP1_OP2 = 3'b110;
    localparam logic [2:0] WM_OP1_R15 = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_OP1    = 2'd1,
        WR_SECOND = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_wb_plan.sv
// Maps an ALU opcode to the set of register-file writes its result needs.
module alu_wb_plan (
    input  logic [2:0] alu_sel,
    output logic [2:0] wr_mask
);
    import alu_pkg::*;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        wr_mask = WM_OP1;
        case (alu_sel)
            ALU_MUL, ALU_DIV: wr_mask = WM_OP1_R15;
            ALU_SWAP:         wr_mask = WM_OP1_OP2;
            default:          wr_mask = WM_OP1;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// Serialises an ALU result bundle into one or two register-file writes,
// accepting the next bundle during the final write so sequences run back-to-back.
module alu_writeback #(
    parameter int DATA_W   = alu_pkg::DATA_W,
    parameter int ADDR_W   = alu_pkg::ADDR_W,
    parameter int R15_ADDR = alu_pkg::R15_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_sel,
    input  logic [ADDR_W-1:0] op1_addr,
    input  logic [ADDR_W-1:0] op2_addr,
    input  logic [DATA_W-1:0] op1data,
    input  logic [DATA_W-1:0] op2data,
    input  logic [DATA_W-1:0] r15,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic [15:0]       retire_cnt
);
    import alu_pkg::*;

    wb_state_e         state_q, state_d;
    logic [2:0]        wr_mask;
    logic [2:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] op1_addr_q, op1_addr_d;
    logic [ADDR_W-1:0] op2_addr_q, op2_addr_d;
    logic [DATA_W-1:0] op1data_q, op1data_d;
    logic [DATA_W-1:0] op2data_q, op2data_d;
    logic [DATA_W-1:0] r15_q, r15_d;
    logic [15:0]       retire_cnt_q, retire_cnt_d;
    logic              accept;
    logic              has_second;
    logic              final_wr;

    alu_wb_plan u_plan (
        .alu_sel (alu_sel),
        .wr_mask (wr_mask)
    );

    assign accept     = in_valid && in_ready;
    assign has_second = mask_q[1] | mask_q[0];
    assign retire_cnt = retire_cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            op1_addr_q   <= '0;
            op2_addr_q   <= '0;
            op1data_q    <= '0;
            op2data_q    <= '0;
            r15_q        <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            op1_addr_q   <= op1_addr_d;
            op2_addr_q   <= op2_addr_d;
            op1data_q    <= op1data_d;
            op2data_q    <= op2data_d;
            r15_q        <= r15_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = WR_OP1;
            WR_OP1: begin
                if (has_second)  state_d = WR_SECOND;
                else if (accept) state_d = WR_OP1;
                else             state_d = IDLE;
            end
            WR_SECOND: state_d = accept ? WR_OP1 : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d       = mask_q;
        op1_addr_d   = op1_addr_q;
        op2_addr_d   = op2_addr_q;
        op1data_d    = op1data_q;
        op2data_d    = op2data_q;
        r15_d        = r15_q;
        retire_cnt_d = final_wr ? retire_cnt_q + 16'd1 : retire_cnt_q;
        if (accept) begin
            mask_d     = wr_mask;
            op1_addr_d = op1_addr;
            op2_addr_d = op2_addr;
            op1data_d  = op1data;
            op2data_d  = op2data;
            r15_d      = r15;
        end
    end

    // in_ready depends only on state and the latched plan, never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        final_wr = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            WR_OP1: begin
                busy     = 1'b1;
                rf_we    = mask_q[2];
                rf_waddr = op1_addr_q;
                rf_wdata = op1data_q;
                final_wr = !has_second;
                in_ready = !has_second;
            end
            WR_SECOND: begin
                busy     = 1'b1;
                rf_we    = 1'b1;
                final_wr = 1'b1;
                in_ready = 1'b1;
                if (mask_q[1]) begin
                    rf_waddr = op2_addr_q;
                    rf_wdata = op2data_q;
                end else begin
                    rf_waddr = ADDR_W'(R15_ADDR);
                    rf_wdata = r15_q;
                end
            end
            default: ;
        endcase
    end

endmodule
